ram_dp_pipe: RTL and testbench

//  Parametrised synchronous word-addressed RAM with two ports: a read/write data port and a

---
 rtl/ram_pkg.sv | 11 +
 rtl/ram_dp_pipe_if.sv | 28 ++
 rtl/ram_rd_pipe.sv | 42 ++++
 rtl/ram_dp_pipe.sv | 100 ++++++++++
 tb/tb_ram_dp_pipe.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port RAM: data-port operation encodings.
package ram_pkg;

  typedef enum logic [1:0] {
    RW_IDLE  = 2'b00,
    RW_READ  = 2'b01,
    RW_WRITE = 2'b10,
    RW_RSVD  = 2'b11
  } rw_e;

endpackage

// File: rtl/ram_dp_pipe_if.sv
// Load/store data port plus instruction-fetch port of the dual-port RAM.
interface ram_dp_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  enable;
  logic [1:0]            rw;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     din;
  logic [DATA_W/8-1:0]   be;
  logic [DATA_W-1:0]     dout;
  logic                  dvalid;
  logic                  fen;
  logic [ADDR_W-1:0]     faddr;
  logic [DATA_W-1:0]     fetch;
  logic                  fvalid;
  logic                  err;

  modport master (
    output enable, rw, addr, din, be, fen, faddr,
    input  dout, dvalid, fetch, fvalid, err
  );

  modport slave (
    input  enable, rw, addr, din, be, fen, faddr,
    output dout, dvalid, fetch, fvalid, err
  );
endinterface

// File: rtl/ram_rd_pipe.sv
// Read-data delay line: READ_LAT register stages, output holds last valid word.
// Latency READ_LAT cycles; no backpressure, accepts one word every cycle.
module ram_rd_pipe #(
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_dat,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_dat
);

  logic [READ_LAT-1:0] vld_q;
  logic [DATA_W-1:0]   dat_q [READ_LAT];

  // Data stages only load on a valid so the final stage holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_vld;
      if (in_vld) begin
        dat_q[0] <= in_dat;
      end
      for (int i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign out_vld = vld_q[READ_LAT-1];
  assign out_dat = dat_q[READ_LAT-1];

endmodule

// File: rtl/ram_dp_pipe.sv
// Word RAM with byte-enabled read/write data port and read-only fetch port.
// Read latency READ_LAT cycles on both ports; no backpressure, one request per port per cycle.
module ram_dp_pipe #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_dp_pipe_if.slave  bus
);
  import ram_pkg::*;

  localparam int                BE_W  = DATA_W / 8;
  localparam int                IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
    $error("ram_dp_pipe: READ_LAT must be 1 or 2");
  end
  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("ram_dp_pipe: DATA_W must be a multiple of 8");
  end

  logic [DATA_W-1:0] ram [0:DEPTH-1];

  logic              d_oor;
  logic              f_oor;
  logic              d_rd;
  logic              d_wr;
  logic              d_bad;
  logic              f_bad;
  logic [IDX_W-1:0]  d_idx;
  logic [IDX_W-1:0]  f_idx;
  logic [DATA_W-1:0] d_rdat;
  logic [DATA_W-1:0] f_rdat;
  logic              err_q;

  // Full-width compare: upper address bits must never alias into the array.
  assign d_oor = (bus.addr  >= LIMIT);
  assign f_oor = (bus.faddr >= LIMIT);
  assign d_idx = bus.addr[IDX_W-1:0];
  assign f_idx = bus.faddr[IDX_W-1:0];

  assign d_rd  = bus.enable && (bus.rw == RW_READ);
  assign d_wr  = bus.enable && (bus.rw == RW_WRITE);
  assign d_bad = (bus.enable && (bus.rw == RW_RSVD)) || ((d_rd || d_wr) && d_oor);
  assign f_bad = bus.fen && f_oor;

  // Combinational reads see the pre-edge contents: same-cycle fetch gets the old word.
  assign d_rdat = d_oor ? '0 : ram[d_idx];
  assign f_rdat = f_oor ? '0 : ram[f_idx];

  // Array is deliberately outside reset so a preloaded image survives it.
  always_ff @(posedge clk) begin
    if (d_wr && !d_oor) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus.be[b]) begin
          ram[d_idx][8*b +: 8] <= bus.din[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= d_bad || f_bad;
    end
  end

  assign bus.err = err_q;

  ram_rd_pipe #(
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_data_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (d_rd),
    .in_dat  (d_rdat),
    .out_vld (bus.dvalid),
    .out_dat (bus.dout)
  );

  ram_rd_pipe #(
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_fetch_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (bus.fen),
    .in_dat  (f_rdat),
    .out_vld (bus.fvalid),
    .out_dat (bus.fetch)
  );

endmodule

// File: tb/tb_ram_dp_pipe.sv
// Bench for ram_dp_pipe: READ_LAT=1 and READ_LAT=2 instances share one stimulus stream.
module tb_ram_dp_pipe;
  import ram_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 256;
  localparam int HIST  = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_dp_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();
  ram_dp_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) b2 ();

  assign b2.enable = b1.enable;
  assign b2.rw     = b1.rw;
  assign b2.addr   = b1.addr;
  assign b2.din    = b1.din;
  assign b2.be     = b1.be;
  assign b2.fen    = b1.fen;
  assign b2.faddr  = b1.faddr;

  ram_dp_pipe #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  ram_dp_pipe #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model: per-edge record of what each request must produce, plus a word array.
  bit [31:0] mem_m [DEPTH];
  bit        dv_h [HIST];
  bit [31:0] dd_h [HIST];
  bit        fv_h [HIST];
  bit [31:0] fd_h [HIST];
  bit        er_h [HIST];
  int        cyc     = 0;
  int        rst_cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      rst_cyc = cyc;
    end else if (cyc < HIST) begin
      dv_h[cyc] = b1.enable && (b1.rw == 2'b01);
      dd_h[cyc] = 32'h0;
      if (b1.addr < DEPTH) dd_h[cyc] = mem_m[b1.addr[7:0]];
      fv_h[cyc] = b1.fen;
      fd_h[cyc] = 32'h0;
      if (b1.faddr < DEPTH) fd_h[cyc] = mem_m[b1.faddr[7:0]];
      er_h[cyc] = (b1.enable && (b1.rw == 2'b11))
               || (b1.enable && (b1.rw == 2'b01 || b1.rw == 2'b10) && b1.addr >= DEPTH)
               || (b1.fen && b1.faddr >= DEPTH);
      if (b1.enable && b1.rw == 2'b10 && b1.addr < DEPTH) begin
        for (int b = 0; b < 4; b++) begin
          if (b1.be[b]) mem_m[b1.addr[7:0]][8*b +: 8] = b1.din[8*b +: 8];
        end
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  bit [31:0]   hd [2];
  bit [31:0]   hf [2];
  logic [31:0] act_d [2];
  logic [31:0] act_f [2];
  logic        act_dv [2];
  logic        act_fv [2];
  logic        act_e [2];

  always @(negedge clk) begin
    bit ev_d, ev_f, ee;
    int idx;
    act_d[0] = b1.dout;   act_d[1] = b2.dout;
    act_f[0] = b1.fetch;  act_f[1] = b2.fetch;
    act_dv[0] = b1.dvalid; act_dv[1] = b2.dvalid;
    act_fv[0] = b1.fvalid; act_fv[1] = b2.fvalid;
    act_e[0] = b1.err;    act_e[1] = b2.err;
    for (int l = 0; l < 2; l++) begin
      idx = cyc - l;
      if (!rst_n) begin
        hd[l] = 0; hf[l] = 0; ev_d = 0; ev_f = 0; ee = 0;
      end else begin
        ev_d = (idx > rst_cyc) && (idx >= 1) && (idx < HIST) && dv_h[idx];
        ev_f = (idx > rst_cyc) && (idx >= 1) && (idx < HIST) && fv_h[idx];
        ee   = (cyc > rst_cyc) && (cyc < HIST) && er_h[cyc];
        if (ev_d) hd[l] = dd_h[idx];
        if (ev_f) hf[l] = fd_h[idx];
      end
      chk($sformatf("cyc%0d L%0d dvalid", cyc, l+1), {31'b0, act_dv[l]}, {31'b0, ev_d});
      chk($sformatf("cyc%0d L%0d dout",   cyc, l+1), act_d[l], hd[l]);
      chk($sformatf("cyc%0d L%0d fvalid", cyc, l+1), {31'b0, act_fv[l]}, {31'b0, ev_f});
      chk($sformatf("cyc%0d L%0d fetch",  cyc, l+1), act_f[l], hf[l]);
      chk($sformatf("cyc%0d L%0d err",    cyc, l+1), {31'b0, act_e[l]}, {31'b0, ee});
    end
  end

  task automatic drv(input bit en, input bit [1:0] rw, input int a, input bit [31:0] d,
                     input bit [3:0] be, input bit fe, input int fa);
    b1.enable = en;
    b1.rw     = rw;
    b1.addr   = 32'(a);
    b1.din    = d;
    b1.be     = be;
    b1.fen    = fe;
    b1.faddr  = 32'(fa);
  endtask

  task automatic idle();
    drv(0, 2'b00, 0, 32'h0, 4'h0, 0, 0);
  endtask

  // Advance past one rising edge to just after the following falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    idle();
    for (int k = 0; k < DEPTH; k++) begin
      u_dut1.ram[k] = 32'(k * 3);
      u_dut2.ram[k] = 32'(k * 3);
      mem_m[k]      = 32'(k * 3);
    end
    #1;
    chk("reset dout",   b1.dout,   32'h0);
    chk("reset dvalid", {31'b0, b1.dvalid}, 32'h0);
    chk("reset fetch",  b2.fetch,  32'h0);
    chk("reset err",    {31'b0, b2.err}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a read burst
    drv(1, 2'b01, 10, 0, 0, 1, 11); tick();
    drv(1, 2'b01, 11, 0, 0, 1, 12); tick();
    chk("burst L1 dout before reset", b1.dout, 32'd33);
    chk("burst L2 dout before reset", b2.dout, 32'd30);
    rst_n = 1'b0;
    #1;
    chk("mid-reset L1 dout",   b1.dout, 32'h0);
    chk("mid-reset L1 dvalid", {31'b0, b1.dvalid}, 32'h0);
    chk("mid-reset L2 dout",   b2.dout, 32'h0);
    chk("mid-reset L2 dvalid", {31'b0, b2.dvalid}, 32'h0);
    tick();
    tick();
    idle();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post-reset L2 dvalid", {31'b0, b2.dvalid}, 32'h0);
    chk("post-reset L2 fvalid", {31'b0, b2.fvalid}, 32'h0);

    // Back-to-back reads 0..7 of the preloaded image
    for (int k = 0; k < 8; k++) begin
      drv(1, 2'b01, k, 0, 0, 0, 0);
      tick();
      chk($sformatf("b2b L1 dout[%0d]", k), b1.dout, 32'(k * 3));
      chk($sformatf("b2b L1 dvalid[%0d]", k), {31'b0, b1.dvalid}, 32'h1);
      if (k > 0) chk($sformatf("b2b L2 dout[%0d]", k), b2.dout, 32'((k - 1) * 3));
    end
    idle();
    tick();
    chk("b2b L1 dvalid end", {31'b0, b1.dvalid}, 32'h0);
    chk("b2b L2 dout last",  b2.dout, 32'd21);
    tick();
    chk("b2b L1 dout held", b1.dout, 32'd21);

    // Byte-enabled write
    drv(1, 2'b10, 5, 32'h11223344, 4'hF, 0, 0); tick();
    chk("write no dvalid", {31'b0, b1.dvalid}, 32'h0);
    drv(1, 2'b10, 5, 32'hAABBCCDD, 4'b0101, 0, 0); tick();
    drv(1, 2'b01, 5, 0, 0, 0, 0); tick();
    chk("be write L1", b1.dout, 32'h11BB33DD);
    drv(1, 2'b10, 6, 32'hFFFFFFFF, 4'h0, 0, 0); tick();
    chk("be write L2", b2.dout, 32'h11BB33DD);
    drv(1, 2'b01, 6, 0, 0, 0, 0); tick();
    chk("be=0 write no-op", b1.dout, 32'd18);

    // Same-cycle write and fetch of one address
    drv(1, 2'b10, 2, 32'hDEADBEEF, 4'hF, 1, 2); tick();
    chk("collision fetch old", b1.fetch, 32'd6);
    chk("collision fvalid",    {31'b0, b1.fvalid}, 32'h1);
    drv(0, 2'b00, 0, 0, 0, 1, 2); tick();
    chk("fetch new L1", b1.fetch, 32'hDEADBEEF);
    chk("fetch old L2", b2.fetch, 32'd6);
    idle(); tick();
    chk("fetch new L2", b2.fetch, 32'hDEADBEEF);

    // Out of range on both ports in one cycle
    drv(1, 2'b01, DEPTH, 0, 0, 1, DEPTH + 1); tick();
    chk("oor err",    {31'b0, b1.err}, 32'h1);
    chk("oor dout",   b1.dout, 32'h0);
    chk("oor dvalid", {31'b0, b1.dvalid}, 32'h1);
    chk("oor fetch",  b1.fetch, 32'h0);
    chk("oor fvalid", {31'b0, b1.fvalid}, 32'h1);
    idle(); tick();
    chk("oor err single pulse", {31'b0, b1.err}, 32'h0);
    chk("oor L2 dvalid", {31'b0, b2.dvalid}, 32'h1);
    drv(1, 2'b10, DEPTH + 3, 32'hFFFFFFFF, 4'hF, 0, 0); tick();
    chk("oor write err", {31'b0, b1.err}, 32'h1);
    drv(1, 2'b01, 3, 0, 0, 1, 0); tick();
    chk("no wrap word 3", b1.dout, 32'd9);
    chk("no wrap word 0", b1.fetch, 32'd0);

    // Reserved op and disabled write
    drv(1, 2'b11, 4, 32'h12345678, 4'hF, 0, 0); tick();
    chk("rsvd err",       {31'b0, b1.err}, 32'h1);
    chk("rsvd no dvalid", {31'b0, b1.dvalid}, 32'h0);
    drv(0, 2'b10, 7, 32'hCAFEF00D, 4'hF, 0, 0); tick();
    chk("disabled write no err", {31'b0, b1.err}, 32'h0);
    drv(1, 2'b01, 7, 0, 0, 1, 4); tick();
    chk("disabled write kept", b1.dout, 32'd21);
    chk("rsvd no write",       b1.fetch, 32'd12);
    idle();
    tick();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
